tx_fifo_arbiter: RTL

Shares the single UART TX FIFO write port between two byte-stream requesters: the ASCII decimal converter (port 0) and the RX echo/status source (port 1). Each requester sends a packet, a run of bytes closed by `last`. The arbiter grants one requester for a whole packet so that digits from different sources never interleave. It handles FIFO back-pressure, alternates grants round-robin on contention, bounds packet length, and can optionally append a CR/LF terminator after each packet.

---
 rtl/tx_fifo_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: packet-level round-robin arbiter sharing one UART TX FIFO write port between two byte requesters
// Ports: CLK/RESET (sync, active-high); reqN/wrN/dataN/lastN from requester N; fifo_full from the FIFO;
//        gntN/rdyN back to requester N; WR_FIFO/data_fifo to the FIFO; ERR pulses on a forced release; STATE for debug.
// Optional feature: define TX_ARB_CRLF_EN to append CR/LF after every released packet.
module tx_fifo_arbiter #(
  parameter int NBIT = 8,
  parameter int MAXLEN = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req0,
  input  logic            req1,
  input  logic            wr0,
  input  logic            wr1,
  input  logic [NBIT-1:0] data0,
  input  logic [NBIT-1:0] data1,
  input  logic            last0,
  input  logic            last1,
  input  logic            fifo_full,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rdy0,
  output logic            rdy1,
  output logic            WR_FIFO,
  output logic [NBIT-1:0] data_fifo,
  output logic            ERR,
  output logic [2:0]      STATE
);
  typedef enum logic [2:0] {IDLE = 3'd0, G0 = 3'd1, G1 = 3'd2, CR = 3'd3, LF = 3'd4} state_t;
  state_t state_q, state_d, rel_st;
  logic ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic acc, lst, req, pick1;
`ifdef TX_ARB_CRLF_EN
  assign rel_st = CR;
`else
  assign rel_st = IDLE;
`endif
  assign gnt0 = state_q == G0;
  assign gnt1 = state_q == G1;
  assign rdy0 = gnt0 & ~fifo_full;
  assign rdy1 = gnt1 & ~fifo_full;
  assign acc = (wr0 & rdy0) | (wr1 & rdy1);
  assign lst = gnt0 ? last0 : last1;
  assign req = gnt0 ? req0 : req1;
  // ptr_q holds the last-served port; on a tie the other one wins
  assign pick1 = ~(req0 & (~req1 | ptr_q));
  assign ERR = err_q;
  assign STATE = state_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    WR_FIFO = 1'b0;
    data_fifo = '0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = pick1 ? G1 : G0;
        ptr_d = pick1;
        cnt_d = '0;
      end
      G0, G1: begin
        data_fifo = gnt0 ? data0 : data1;
        WR_FIFO = acc;
        cnt_d = cnt_q + 8'(acc);
        // a forced release is a MAXLEN-th accepted byte without last
        if (acc & (lst | (cnt_q == 8'(MAXLEN - 1)))) begin
          state_d = rel_st;
          err_d = ~lst;
        end else if (~req) state_d = IDLE;
      end
`ifdef TX_ARB_CRLF_EN
      CR: begin
        data_fifo = NBIT'(8'h0D);
        WR_FIFO = ~fifo_full;
        state_d = fifo_full ? CR : LF;
      end
      LF: begin
        data_fifo = NBIT'(8'h0A);
        WR_FIFO = ~fifo_full;
        state_d = fifo_full ? LF : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q <= 1'b1;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule
